// File: rtl/mv_layer_sched.sv
// mv_layer_sched: walks a chain of fully-connected layers through the
// matrix-vector engine. Each accepted descriptor is programmed over the
// engine's config bus (indices 0..7, index 7 = go), then the status register
// (index 8, bit0 = over) is polled until the layer finishes. Intermediate
// vectors ping-pong between scratch buffers A and B; the last layer writes
// to out_addr.
// Optional: define MV_LAYER_SCHED_WDOG_EN to add a 24-bit POLL watchdog that
// stops the engine (index 7 <- 0), flags err and ends the job.
module mv_layer_sched #(
  parameter int XAW      = 32,
  parameter int CW       = 10,
  parameter int LW       = 30,
  parameter int POLL_GAP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XAW-1:0]   in_addr,
  input  logic [XAW-1:0]   buf_a,
  input  logic [XAW-1:0]   buf_b,
  input  logic [XAW-1:0]   out_addr,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [XAW-1:0]   desc_waddr,
  input  logic [XAW-1:0]   desc_baddr,
  input  logic [CW-1:0]    desc_olen,
  input  logic [LW-1:0]    desc_ilen,
  input  logic             desc_last,
  output logic             config_ena,
  output logic [5:0]       config_addr,
  output logic [31:0]      config_wdata,
  input  logic [31:0]      config_rdata,
  output logic             busy,
  output logic             done,
  output logic [7:0]       layer_cnt,
  output logic             err
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WRITE, S_POLL, S_FINISH} state_e;
  typedef enum logic {SEL_A, SEL_B} sel_e;

  localparam int         PGW    = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP + 1);
  localparam logic [5:0] IDX_GO = 6'd7;
  localparam logic [5:0] IDX_ST = 6'd8;

  state_e           state_q, state_d;
  sel_e             sel_q, sel_d;
  logic [XAW-1:0]   cur_in_q, cur_in_d;
  logic [XAW-1:0]   d_waddr_q, d_waddr_d;
  logic [XAW-1:0]   d_baddr_q, d_baddr_d;
  logic [CW-1:0]    d_olen_q, d_olen_d;
  logic [LW-1:0]    d_ilen_q, d_ilen_d;
  logic             d_last_q, d_last_d;
  logic [PGW-1:0]   poll_wait_q, poll_wait_d;
  logic             desc_ready_q, desc_ready_d;
  logic             config_ena_q, config_ena_d;
  logic [5:0]       config_addr_q, config_addr_d;
  logic [31:0]      config_wdata_q, config_wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       layer_cnt_q, layer_cnt_d;
  logic             err_q, err_d;
`ifdef MV_LAYER_SCHED_WDOG_EN
  logic [23:0]      wdog_q, wdog_d;
`endif

  logic [2:0]       next_idx;
  logic [XAW-1:0]   oaddr_lat;
  logic [31:0]      next_wdata;
  logic             complete;
  logic             cmp_last;
  logic [XAW-1:0]   cmp_oaddr;
  logic             rdata_unused;

  // Only the over flag of the status word is meaningful.
  assign rdata_unused = ^config_rdata[31:1];

  assign next_idx  = config_addr_q[2:0] + 3'd1;
  assign oaddr_lat = d_last_q ? out_addr : ((sel_q == SEL_A) ? buf_a : buf_b);

  // Write data for the config index that follows the one currently on the bus.
  always_comb begin
    case (next_idx)
      3'd0:    next_wdata = 32'(d_waddr_q);
      3'd1:    next_wdata = 32'(cur_in_q);
      3'd2:    next_wdata = 32'(d_baddr_q);
      3'd3:    next_wdata = 32'(oaddr_lat);
      3'd4:    next_wdata = 32'(d_olen_q);
      3'd5:    next_wdata = 32'(d_ilen_q);
      3'd6:    next_wdata = 32'(d_ilen_q) << 2;
      default: next_wdata = 32'd1;
    endcase
  end

  // Next-state and next-output logic of the layer sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d        = state_q;
    sel_d          = sel_q;
    cur_in_d       = cur_in_q;
    d_waddr_d      = d_waddr_q;
    d_baddr_d      = d_baddr_q;
    d_olen_d       = d_olen_q;
    d_ilen_d       = d_ilen_q;
    d_last_d       = d_last_q;
    poll_wait_d    = poll_wait_q;
    desc_ready_d   = desc_ready_q;
    config_ena_d   = 1'b0;
    config_addr_d  = config_addr_q;
    config_wdata_d = '0;
    busy_d         = busy_q;
    done_d         = 1'b0;
    layer_cnt_d    = layer_cnt_q;
    err_d          = err_q;
    complete       = 1'b0;
    cmp_last       = 1'b0;
    cmp_oaddr      = '0;
`ifdef MV_LAYER_SCHED_WDOG_EN
    wdog_d         = wdog_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_in_d     = in_addr;
          layer_cnt_d  = '0;
          err_d        = 1'b0;
          sel_d        = SEL_A;
          busy_d       = 1'b1;
          desc_ready_d = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_FETCH: begin
        if (desc_valid) begin
          d_waddr_d    = desc_waddr;
          d_baddr_d    = desc_baddr;
          d_olen_d     = desc_olen;
          d_ilen_d     = desc_ilen;
          d_last_d     = desc_last;
          desc_ready_d = 1'b0;
          if (desc_olen == '0 || desc_ilen == '0) begin
            // Degenerate layer: flag it and treat it as finished without
            // touching the engine.
            err_d     = 1'b1;
            complete  = 1'b1;
            cmp_last  = desc_last;
            cmp_oaddr = desc_last ? out_addr : ((sel_q == SEL_A) ? buf_a : buf_b);
          end else begin
            state_d        = S_WRITE;
            config_ena_d   = 1'b1;
            config_addr_d  = '0;
            config_wdata_d = 32'(desc_waddr);
          end
        end
      end

      S_WRITE: begin
        if (config_addr_q == IDX_GO) begin
          state_d       = S_POLL;
          config_addr_d = IDX_ST;
          // The read right after go returns stale data, so skip one sample.
          poll_wait_d   = PGW'(1);
`ifdef MV_LAYER_SCHED_WDOG_EN
          wdog_d        = '0;
`endif
        end else begin
          config_ena_d   = 1'b1;
          config_addr_d  = {3'd0, next_idx};
          config_wdata_d = next_wdata;
        end
      end

      S_POLL: begin
        if (poll_wait_q != '0) begin
          poll_wait_d = poll_wait_q - PGW'(1);
        end else if (config_rdata[0]) begin
          complete  = 1'b1;
          cmp_last  = d_last_q;
          cmp_oaddr = oaddr_lat;
        end else begin
          poll_wait_d = PGW'(POLL_GAP);
        end
`ifdef MV_LAYER_SCHED_WDOG_EN
        if (!complete) begin
          if (wdog_q == '1) begin
            err_d          = 1'b1;
            config_ena_d   = 1'b1;
            config_addr_d  = IDX_GO;
            config_wdata_d = '0;
            done_d         = 1'b1;
            busy_d         = 1'b0;
            state_d        = S_FINISH;
          end else begin
            wdog_d = wdog_q + 24'd1;
          end
        end
`endif
      end

      S_FINISH: begin
        config_addr_d = '0;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      layer_cnt_d   = (layer_cnt_q == 8'hFF) ? 8'hFF : layer_cnt_q + 8'd1;
      cur_in_d      = cmp_oaddr;
      sel_d         = (sel_q == SEL_A) ? SEL_B : SEL_A;
      config_addr_d = '0;
      if (cmp_last) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_FINISH;
      end else begin
        desc_ready_d = 1'b1;
        state_d      = S_FETCH;
      end
    end
  end

  // State and registered outputs; reset aborts any job immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      sel_q          <= SEL_A;
      cur_in_q       <= '0;
      d_waddr_q      <= '0;
      d_baddr_q      <= '0;
      d_olen_q       <= '0;
      d_ilen_q       <= '0;
      d_last_q       <= 1'b0;
      poll_wait_q    <= '0;
      desc_ready_q   <= 1'b0;
      config_ena_q   <= 1'b0;
      config_addr_q  <= '0;
      config_wdata_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      layer_cnt_q    <= '0;
      err_q          <= 1'b0;
`ifdef MV_LAYER_SCHED_WDOG_EN
      wdog_q         <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      state_q        <= state_d;
      sel_q          <= sel_d;
      cur_in_q       <= cur_in_d;
      d_waddr_q      <= d_waddr_d;
      d_baddr_q      <= d_baddr_d;
      d_olen_q       <= d_olen_d;
      d_ilen_q       <= d_ilen_d;
      d_last_q       <= d_last_d;
      poll_wait_q    <= poll_wait_d;
      desc_ready_q   <= desc_ready_d;
      config_ena_q   <= config_ena_d;
      config_addr_q  <= config_addr_d;
      config_wdata_q <= config_wdata_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      layer_cnt_q    <= layer_cnt_d;
      err_q          <= err_d;
`ifdef MV_LAYER_SCHED_WDOG_EN
      wdog_q         <= wdog_d;
`endif
    end
  end

  assign desc_ready   = desc_ready_q;
  assign config_ena   = config_ena_q;
  assign config_addr  = config_addr_q;
  assign config_wdata = config_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign layer_cnt    = layer_cnt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mv_layer_sched.sv
// Self-checking bench for mv_layer_sched: directed jobs from the test plan
// plus randomized layer chains, checked against a descriptor-level model of
// the expected config writes, handshake timing and job results.
module tb_mv_layer_sched;

  localparam int XAW      = 32;
  localparam int CW       = 10;
  localparam int LW       = 30;
  localparam int POLL_GAP = 4;
  localparam int BUDGET   = 1000;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [XAW-1:0]  in_addr, buf_a, buf_b, out_addr;
  logic            desc_valid;
  logic            desc_ready;
  logic [XAW-1:0]  desc_waddr, desc_baddr;
  logic [CW-1:0]   desc_olen;
  logic [LW-1:0]   desc_ilen;
  logic            desc_last;
  logic            config_ena;
  logic [5:0]      config_addr;
  logic [31:0]     config_wdata;
  logic [31:0]     config_rdata;
  logic            busy, done, err;
  logic [7:0]      layer_cnt;

  mv_layer_sched #(.XAW(XAW), .CW(CW), .LW(LW), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_addr(in_addr), .buf_a(buf_a), .buf_b(buf_b), .out_addr(out_addr),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_waddr(desc_waddr), .desc_baddr(desc_baddr),
    .desc_olen(desc_olen), .desc_ilen(desc_ilen), .desc_last(desc_last),
    .config_ena(config_ena), .config_addr(config_addr),
    .config_wdata(config_wdata), .config_rdata(config_rdata),
    .busy(busy), .done(done), .layer_cnt(layer_cnt), .err(err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] baddr;
    logic [9:0]  olen;
    logic [29:0] ilen;
    bit          last;
    int          lat;
    int          dly;
    bit          poke;
  } desc_t;

  typedef struct { logic [5:0] addr; logic [31:0] data; } cw_t;
  typedef struct { int cyc; logic [5:0] addr; logic [31:0] data; } wr_t;

  desc_t jd[$];
  wr_t   wr_q[$];
  cw_t   exp_q[$];
  int    exp_cyc[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int eng_lat  = 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " desc_ready"},   desc_ready,   0);
    check({tag, " config_ena"},   config_ena,   0);
    check({tag, " config_addr"},  config_addr,  0);
    check({tag, " config_wdata"}, config_wdata, 0);
    check({tag, " busy"},         busy,         0);
    check({tag, " done"},         done,         0);
    check({tag, " layer_cnt"},    layer_cnt,    0);
    check({tag, " err"},          err,          0);
  endtask

  // Cycle counter: the value seen at a negedge names the cycle in progress.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: record every config write with the cycle it was on the bus.
  initial forever begin
    @(negedge clk);
    if (rst && config_ena) wr_q.push_back('{cyc, config_addr, config_wdata});
  end

  // Engine model: over rises eng_lat cycles after go; status is returned one
  // cycle after index 8 is presented as a read.
  initial begin
    logic [5:0] prv_addr;
    logic       prv_ena, prv_over, go_seen;
    int         go_cyc;
    config_rdata = '0;
    prv_addr = '0; prv_ena = 1'b0; prv_over = 1'b0; go_seen = 1'b0; go_cyc = 0;
    forever begin
      @(negedge clk);
      config_rdata = (prv_addr == 6'd8 && !prv_ena) ? {31'd0, prv_over} : 32'd0;
      if (config_ena && config_addr == 6'd7 && config_wdata == 32'd1) begin
        go_seen = 1'b1;
        go_cyc  = cyc;
      end
      prv_over = go_seen && ((cyc - go_cyc) >= eng_lat);
      prv_addr = config_addr;
      prv_ena  = config_ena;
    end
  end

  // Reference: expected config writes, final layer count and error flag.
  task automatic build_model(input logic [31:0] ia, ba, bb, oa, output int cnt, output bit e);
    logic [31:0] cur, oaddr;
    logic [63:0] woff;
    bit          on_b;
    exp_q.delete();
    cur = ia; on_b = 1'b0; cnt = 0; e = 1'b0;
    foreach (jd[i]) begin
      oaddr = jd[i].last ? oa : (on_b ? bb : ba);
      if (jd[i].olen == 0 || jd[i].ilen == 0) begin
        e = 1'b1;
      end else begin
        woff = 64'(jd[i].ilen) * 64'd4;
        exp_q.push_back('{6'd0, jd[i].waddr});
        exp_q.push_back('{6'd1, cur});
        exp_q.push_back('{6'd2, jd[i].baddr});
        exp_q.push_back('{6'd3, oaddr});
        exp_q.push_back('{6'd4, 32'(jd[i].olen)});
        exp_q.push_back('{6'd5, 32'(jd[i].ilen)});
        exp_q.push_back('{6'd6, woff[31:0]});
        exp_q.push_back('{6'd7, 32'd1});
      end
      if (cnt < 255) cnt++;
      cur  = oaddr;
      on_b = !on_b;
    end
  endtask

  // Run the job held in jd; called at a negedge.
  task automatic run_job(input logic [31:0] ia, ba, bb, oa, input string name);
    int s, a, exp_t, t, cnt, g, sp, n;
    bit e;
    build_model(ia, ba, bb, oa, cnt, e);
    exp_cyc.delete();
    wr_q.delete();
    in_addr = ia; buf_a = ba; buf_b = bb; out_addr = oa;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    exp_t = s + 1;
    foreach (jd[i]) begin
      t = 0;
      while (!desc_ready && t < BUDGET) begin
        @(negedge clk);
        t++;
      end
      if (!desc_ready) begin
        check($sformatf("%s L%0d ready timeout", name, i), 0, 1);
        return;
      end
      check($sformatf("%s L%0d ready cycle", name, i), cyc, exp_t);
      check($sformatf("%s L%0d busy", name, i), busy, 1);
      for (int k = 0; k < jd[i].dly; k++) begin
        if (jd[i].poke && k == 0) begin
          start   = 1'b1;
          in_addr = ~ia;
        end
        @(negedge clk);
        start = 1'b0;
      end
      if (jd[i].dly > 0) check($sformatf("%s L%0d ready hold", name, i), desc_ready, 1);
      desc_valid = 1'b1;
      desc_waddr = jd[i].waddr;
      desc_baddr = jd[i].baddr;
      desc_olen  = jd[i].olen;
      desc_ilen  = jd[i].ilen;
      desc_last  = jd[i].last;
      eng_lat    = jd[i].lat;
      a = cyc;
      @(negedge clk);
      desc_valid = 1'b0;
      desc_waddr = $urandom;
      desc_baddr = $urandom;
      desc_olen  = 10'($urandom);
      desc_ilen  = 30'($urandom);
      desc_last  = 1'($urandom);
      if (jd[i].olen == 0 || jd[i].ilen == 0) begin
        exp_t = a + 1;
      end else begin
        for (int k = 0; k < 8; k++) exp_cyc.push_back(a + 1 + k);
        g  = a + 8;
        sp = g + 2;
        while (sp < g + jd[i].lat + 1) sp += POLL_GAP + 1;
        exp_t = sp + 1;
      end
    end
    t = 0;
    while (!done && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    check({name, " done seen"}, done, 1);
    check({name, " done cycle"}, cyc, exp_t);
    check({name, " busy at done"}, busy, 0);
    check({name, " layer_cnt"}, layer_cnt, cnt);
    check({name, " err"}, err, e);
    @(negedge clk);
    check({name, " done pulse width"}, done, 0);
    check({name, " write count"}, wr_q.size(), exp_q.size());
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s wr%0d addr", name, k), wr_q[k].addr, exp_q[k].addr);
      check($sformatf("%s wr%0d data", name, k), wr_q[k].data, exp_q[k].data);
      check($sformatf("%s wr%0d cycle", name, k), wr_q[k].cyc, exp_cyc[k]);
    end
  endtask

  function automatic desc_t mk(input logic [31:0] w, b, input logic [9:0] ol,
                               input logic [29:0] il, input bit last, input int lat,
                               input int dly, input bit poke);
    desc_t d;
    d.waddr = w; d.baddr = b; d.olen = ol; d.ilen = il;
    d.last = last; d.lat = lat; d.dly = dly; d.poke = poke;
    return d;
  endfunction

  initial begin
    #900000;
    $display("FAIL global timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int a, t, nl;
    rst = 1'b1; start = 1'b0; desc_valid = 1'b0;
    in_addr = '0; buf_a = '0; buf_b = '0; out_addr = '0;
    desc_waddr = '0; desc_baddr = '0; desc_olen = '0; desc_ilen = '0; desc_last = 1'b0;
    #1 rst = 1'b0;
    #2 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single layer from the plan.
    jd.delete();
    jd.push_back(mk(32'h2000, 32'h3000, 10'd8, 30'd64, 1, 50, 0, 0));
    run_job(32'h1000, 32'hA000, 32'hB000, 32'hC000, "single");

    // Three-layer chain, slow layer for poll spacing, backpressure + stray start.
    jd.delete();
    jd.push_back(mk(32'h1_0000, 32'h2_0000, 10'd16, 30'd32, 0, 20, 0, 0));
    jd.push_back(mk(32'h1_1000, 32'h2_1000, 10'd4, 30'd16, 0, 3, 10, 1));
    jd.push_back(mk(32'h1_2000, 32'h2_2000, 10'd1023, 30'h3FFF_FFFF, 1, 1, 0, 0));
    run_job(32'h5000, 32'hA000, 32'hB000, 32'hD000, "chain3");

    // Zero rows: error, no engine writes, layer still counted.
    jd.delete();
    jd.push_back(mk(32'h7000, 32'h8000, 10'd0, 30'd12, 1, 5, 0, 0));
    run_job(32'h6000, 32'hA000, 32'hB000, 32'hE000, "zero_rows");

    // Error clears on the next start.
    jd.delete();
    jd.push_back(mk(32'h100, 32'h200, 10'd2, 30'd2, 1, 2, 1, 0));
    run_job(32'h300, 32'h400, 32'h500, 32'h600, "after_err");

    // Reset during the index-3 write.
    jd.delete();
    wr_q.delete();
    in_addr = 32'h1000; buf_a = 32'hA000; buf_b = 32'hB000; out_addr = 32'hC000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!desc_ready && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    check("rst ready seen", desc_ready, 1);
    desc_valid = 1'b1; desc_waddr = 32'h2000; desc_baddr = 32'h3000;
    desc_olen = 10'd8; desc_ilen = 30'd64; desc_last = 1'b1; eng_lat = 5;
    a = cyc;
    @(negedge clk);
    desc_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst pre idx", config_addr, 3);
    check("rst pre ena", config_ena, 1);
    check("rst pre cycle", cyc, a + 4);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midjob");
    @(negedge clk);
    check("rst writes before", wr_q.size(), 4);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("rst writes after", wr_q.size(), 4);
    check("rst busy after", busy, 0);
    check("rst done after", done, 0);

    // Randomized chains.
    for (int j = 0; j < 20; j++) begin
      jd.delete();
      nl = $urandom_range(1, 4);
      for (int i = 0; i < nl; i++) begin
        desc_t d;
        d.waddr = $urandom;
        d.baddr = $urandom;
        d.olen  = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        d.ilen  = ($urandom_range(0, 9) == 0) ? 30'd0 : 30'($urandom_range(1, 32'h3FFF_FFFF));
        d.last  = (i == nl - 1);
        d.lat   = $urandom_range(1, 40);
        d.dly   = $urandom_range(0, 4);
        d.poke  = ($urandom_range(0, 3) == 0);
        jd.push_back(d);
      end
      run_job($urandom, $urandom, $urandom, $urandom, $sformatf("rnd%0d", j));
    end

    // Long chain: layer count saturates at 255.
    jd.delete();
    for (int i = 0; i < 260; i++)
      jd.push_back(mk(32'(i), 32'(i + 1000), 10'd1, 30'd1, (i == 259), 1, 0, 0));
    run_job(32'h40, 32'h50, 32'h60, 32'h70, "sat");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mv_layer_sched.md
Name: mv_layer_sched

Overview:
- Sequences a chain of fully-connected layers through the matrix-vector engine.
- Accepts layer descriptors on a valid/ready stream and programs each layer's parameters over the engine's 6-bit config bus, then starts it.
- Polls the engine's completion flag and ping-pongs intermediate vectors between two scratch buffers.
- Sits between the host/command processor and the matrix-vector engine's config port.

Parameters:
- XAW, 32, external address width
- CW, 10, output-length (rows) width
- LW, 30, input-length width
- POLL_GAP, 4, idle cycles between status polls (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a job (ignored unless idle)
- in_addr  in  XAW  first layer input vector base
- buf_a  in  XAW  scratch buffer A base
- buf_b  in  XAW  scratch buffer B base
- out_addr  in  XAW  final layer output base
- desc_valid  in  1  descriptor valid
- desc_ready  out  1  descriptor accepted when valid&ready
- desc_waddr  in  XAW  weight base
- desc_baddr  in  XAW  bias base
- desc_olen  in  CW  output rows
- desc_ilen  in  LW  input length
- desc_last  in  1  final layer of job
- config_ena  out  1  config write strobe
- config_addr  out  6  config register index
- config_wdata  out  32  config write data
- config_rdata  in  32  config read data, registered (valid 1 cycle after config_addr with config_ena=0)
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job completion
- layer_cnt  out  8  layers completed in current job
- err  out  1  sticky error, cleared by start

Behaviour:
- Reset values: desc_ready=0, config_ena=0, config_addr=0, config_wdata=0, busy=0, done=0, layer_cnt=0, err=0; FSM to IDLE; asynchronous assertion, synchronous deassertion.
- Config map (decided): 0 waddr, 1 iaddr, 2 baddr, 3 oaddr, 4 olen, 5 ilen, 6 woffset, 7 go (wdata=1), 8 status (bit0=over, read-only).
- IDLE: on start, latch in_addr as cur_in, clear layer_cnt/err, set sel=A; go to FETCH; busy=1.
- FETCH: desc_ready=1; on handshake latch descriptor; go to WRITE.
- Output address selection: oaddr = out_addr if desc_last, else buf_a if sel=A, else buf_b.
- WRITE: issue indices 0..7 on consecutive cycles, config_ena=1 each cycle, 8 cycles total.
  - Write data: iaddr=cur_in; woffset = desc_ilen<<2 truncated to 32 bits; olen/ilen zero-extended.
  - Index 7 writes go.
- POLL: config_ena=0, config_addr=8. Wait 1 cycle; sample config_rdata[0].
  - If 0: wait POLL_GAP cycles, then re-poll.
  - If 1: layer_cnt+1 (saturates at 255); cur_in=oaddr; sel toggles.
  - Next state: if last, go to FINISH; else go to FETCH.
- The status sample in the cycle immediately after the go write is ignored; the first valid poll starts 2 cycles after go.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- start while busy: ignored.
- desc_valid while not in FETCH: not accepted (desc_ready=0).
- Rows zero: desc_olen=0 or desc_ilen=0 sets err, skips WRITE/POLL, and the layer counts as done.
- Reset mid-job: abort immediately; no further config writes.
- Latency from descriptor accept to go write: 8 cycles. Minimum layer overhead: 8+2 cycles.

Optional Feature:
- Macro: MV_LAYER_SCHED_WDOG_EN.
- Enabled: a 24-bit watchdog counts cycles in POLL. On reaching 2^24-1 without over=1:
  - err=1;
  - write 0 to index 7 (stop);
  - pulse done;
  - return to IDLE.
- Disabled: POLL waits indefinitely; no counter is synthesized.

Test Plan:
- Single layer: start, in_addr=0x1000, desc{waddr=0x2000, baddr=0x3000, olen=8, ilen=64, last=1}.
  - Writes idx0..7 = 0x2000, 0x1000, 0x3000, out_addr, 8, 64, 256, 1.
  - over raised after 50 cycles leads to a done pulse; layer_cnt=1.
- Three-layer chain: buf_a=0xA000, buf_b=0xB000.
  - oaddr sequence 0xA000, 0xB000, out_addr.
  - iaddr sequence in_addr, 0xA000, 0xB000; layer_cnt=3.
- Poll spacing: over held 0 for 20 cycles with POLL_GAP=4. Status reads spaced 5 cycles apart; no writes during POLL.
- Backpressure: desc_valid delayed 10 cycles after FETCH. desc_ready held high, no config activity; start pulse mid-job ignored.
- Zero rows and reset: olen=0 gives err=1 with no go write. Reset asserted during WRITE idx3 forces all outputs to reset values with no further config_ena.
- Watchdog (with MV_LAYER_SCHED_WDOG_EN): over never set gives err=1 and an idx7=0 write at 2^24-1 poll cycles, then done.
